logic_op_sequencer: RTL and testbench

Sequential front end for the team's 4-bit bitwise logic units. Accepts operand A, then operand B plus an opcode, over a single valid/ready input channel. Computes AND/OR/XOR/NAND and holds the registered result on a valid/ready output channel until the consumer takes it. Sits between the operand source (register file / test driver) and the ALU result bus, giving the combinational gate modules a handshaked, registered wrapper.

---
 rtl/logic_op_sequencer.sv | 156 +++++++++++++++
 tb/tb_logic_op_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_sequencer.sv
// Handshaked two-operand front end for the 4-bit bitwise logic units (AND/OR/XOR/NAND).
// Optional zero/parity result flags are enabled by defining LOGIC_SEQ_FLAGS_EN.
module logic_op_sequencer #(
  parameter int k = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [k-1:0] in_data,
  input  logic [1:0]   in_op,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [k-1:0] out_data,
  output logic         busy
`ifdef LOGIC_SEQ_FLAGS_EN
  ,
  output logic         out_zero,
  output logic         out_parity
`endif
);

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  logic [1:0]   state_r;
  logic [1:0]   nextState_s;
  logic [k-1:0] heldA_r;
  logic [k-1:0] outData_r;
  logic [k-1:0] result_s;
  logic         loadA_s;
  logic         clearA_s;
  logic         loadResult_s;

  function automatic logic [k-1:0] applyOp(input logic [k-1:0] a,
                                           input logic [k-1:0] b,
                                           input logic [1:0]   op);
    logic [k-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~(a & b);
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic calcParity(input logic [k-1:0] v);
    return ^v;
  endfunction

  // Channel status is a pure decode of the state register, never of the partner's strobe.
  assign in_ready  = (state_r == LOAD_A) || (state_r == LOAD_B);
  assign out_valid = (state_r == RESULT);
  assign busy      = (state_r != LOAD_A);
  assign out_data  = outData_r;
  assign result_s  = applyOp(heldA_r, in_data, in_op);

  // Next-state and register-enable decode; abort in LOAD_B outranks a same-cycle B.
  always_comb begin
    nextState_s  = state_r;
    loadA_s      = 1'b0;
    clearA_s     = 1'b0;
    loadResult_s = 1'b0;
    case (state_r)
      LOAD_A: begin
        if (in_valid) begin
          nextState_s = LOAD_B;
          loadA_s     = 1'b1;
        end else begin
          nextState_s = LOAD_A;
        end
      end
      LOAD_B: begin
        if (abort) begin
          nextState_s = LOAD_A;
          clearA_s    = 1'b1;
        end else if (in_valid) begin
          nextState_s  = RESULT;
          loadResult_s = 1'b1;
        end else begin
          nextState_s = LOAD_B;
        end
      end
      RESULT: begin
        if (out_ready) begin
          nextState_s = LOAD_A;
        end else begin
          nextState_s = RESULT;
        end
      end
      default: begin
        nextState_s = LOAD_A;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOAD_A;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Held operand A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heldA_r <= {k{1'b0}};
    end else if (loadA_s) begin
      heldA_r <= in_data;
    end else if (clearA_s) begin
      heldA_r <= {k{1'b0}};
    end else begin
      heldA_r <= heldA_r;
    end
  end

  // Result register; keeps its value after the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData_r <= {k{1'b0}};
    end else if (loadResult_s) begin
      outData_r <= result_s;
    end else begin
      outData_r <= outData_r;
    end
  end

`ifdef LOGIC_SEQ_FLAGS_EN
  logic zero_r;
  logic parity_r;

  // Flags are captured together with the result so they stay coherent with out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_r   <= 1'b1;
      parity_r <= 1'b0;
    end else if (loadResult_s) begin
      zero_r   <= (result_s == {k{1'b0}});
      parity_r <= calcParity(result_s);
    end else begin
      zero_r   <= zero_r;
      parity_r <= parity_r;
    end
  end

  assign out_zero   = zero_r;
  assign out_parity = parity_r;
`endif

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed, table-driven bench for logic_op_sequencer plus hand-written backpressure,
// abort and asynchronous-reset sequences. Flag checks apply when LOGIC_SEQ_FLAGS_EN is defined.
module tb_logic_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       inValid;
  logic       inReady;
  logic [3:0] inData;
  logic [1:0] inOp;
  logic       abortIn;
  logic       outValid;
  logic       outReady;
  logic [3:0] outData;
  logic       busy;
`ifdef LOGIC_SEQ_FLAGS_EN
  logic       outZero;
  logic       outParity;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] expData;
    logic       expZero;
    logic       expParity;
  } vec_t;

  vec_t vecs[10];

  logic_op_sequencer #(.k(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .in_op     (inOp),
    .abort     (abortIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .busy      (busy)
`ifdef LOGIC_SEQ_FLAGS_EN
    ,
    .out_zero  (outZero),
    .out_parity(outParity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, " out_valid"}, {31'd0, outValid}, 32'd0);
    check({tag, " busy"},      {31'd0, busy},     32'd0);
    check({tag, " in_ready"},  {31'd0, inReady},  32'd1);
  endtask

  // Full transaction with out_ready held high: result is visible for exactly one cycle.
  task automatic runVec(input vec_t v, input string tag);
    @(negedge clk);
    inValid = 1'b1; inData = v.a; inOp = 2'b00;
    @(posedge clk); #1;
    check({tag, " busy after A"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    inData = v.b; inOp = v.op;
    @(posedge clk); #1;
    check({tag, " out_valid"}, {31'd0, outValid}, 32'd1);
    check({tag, " out_data"},  {28'd0, outData},  {28'd0, v.expData});
    check({tag, " in_ready in RESULT"}, {31'd0, inReady}, 32'd0);
`ifdef LOGIC_SEQ_FLAGS_EN
    check({tag, " out_zero"},   {31'd0, outZero},   {31'd0, v.expZero});
    check({tag, " out_parity"}, {31'd0, outParity}, {31'd0, v.expParity});
`endif
    @(negedge clk);
    inValid = 1'b0;
    @(posedge clk); #1;
    checkIdle({tag, " after handshake"});
    check({tag, " out_data kept"}, {28'd0, outData}, {28'd0, v.expData});
  endtask

  initial begin
    vec_t pre;
    vecs[0] = '{4'b1111, 4'b1010, 2'b00, 4'b1010, 1'b0, 1'b0};
    vecs[1] = '{4'b1100, 4'b1010, 2'b00, 4'b1000, 1'b0, 1'b1};
    vecs[2] = '{4'b1100, 4'b1010, 2'b01, 4'b1110, 1'b0, 1'b1};
    vecs[3] = '{4'b1100, 4'b1010, 2'b10, 4'b0110, 1'b0, 1'b0};
    vecs[4] = '{4'b1100, 4'b1010, 2'b11, 4'b0111, 1'b0, 1'b1};
    vecs[5] = '{4'b0000, 4'b0000, 2'b11, 4'b1111, 1'b0, 1'b0};
    vecs[6] = '{4'b0000, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0};
    vecs[7] = '{4'b0111, 4'b1111, 2'b00, 4'b0111, 1'b0, 1'b1};
    vecs[8] = '{4'b1001, 4'b0110, 2'b10, 4'b1111, 1'b0, 1'b0};
    vecs[9] = '{4'b1010, 4'b0101, 2'b01, 4'b1111, 1'b0, 1'b0};

    rst_n = 1'b0; inValid = 1'b0; inData = 4'b0000; inOp = 2'b00;
    abortIn = 1'b0; outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    check("reset out_data", {28'd0, outData}, 32'd0);
`ifdef LOGIC_SEQ_FLAGS_EN
    check("reset out_zero",   {31'd0, outZero},   32'd1);
    check("reset out_parity", {31'd0, outParity}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles while in_valid is ignored.
    outReady = 1'b0;
    @(negedge clk);
    inValid = 1'b1; inData = 4'b1001;
    @(negedge clk);
    inData = 4'b0101; inOp = 2'b10;
    @(posedge clk); #1;
    @(negedge clk);
    inData = 4'b0000; inOp = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp out_valid", {31'd0, outValid}, 32'd1);
      check("bp out_data",  {28'd0, outData},  32'h0000000c);
      check("bp in_ready",  {31'd0, inReady},  32'd0);
    end
    @(negedge clk);
    outReady = 1'b1; inValid = 1'b0;
    @(posedge clk); #1;
    checkIdle("bp release");
    @(posedge clk); #1;
    check("bp single transfer", {31'd0, outValid}, 32'd0);
    check("bp data kept", {28'd0, outData}, 32'h0000000c);

    // Abort in LOAD_B drops the same-cycle B.
    @(negedge clk);
    inValid = 1'b1; inData = 4'b0101;
    @(negedge clk);
    inData = 4'b1111; inOp = 2'b00; abortIn = 1'b1;
    @(posedge clk); #1;
    checkIdle("abort");
    check("abort out_data untouched", {28'd0, outData}, 32'h0000000c);
    @(negedge clk);
    inValid = 1'b0; abortIn = 1'b0;
    @(posedge clk); #1;
    check("abort no result", {31'd0, outValid}, 32'd0);

    // Abort is ignored while loading A.
    @(negedge clk);
    inValid = 1'b1; inData = 4'b0011; abortIn = 1'b1;
    @(posedge clk); #1;
    check("abort in LOAD_A ignored", {31'd0, busy}, 32'd1);
    @(negedge clk);
    abortIn = 1'b0; inData = 4'b0001; inOp = 2'b01;
    @(posedge clk); #1;
    check("post-abort out_valid", {31'd0, outValid}, 32'd1);
    check("post-abort out_data",  {28'd0, outData},  32'h00000003);
    @(negedge clk);
    inValid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset while in LOAD_B.
    @(negedge clk);
    inValid = 1'b1; inData = 4'b1110;
    @(posedge clk); #1;
    @(negedge clk);
    inValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkIdle("rst in LOAD_B");
    check("rst in LOAD_B out_data", {28'd0, outData}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while a result is waiting.
    outReady = 1'b0;
    @(negedge clk);
    inValid = 1'b1; inData = 4'b1111;
    @(negedge clk);
    inData = 4'b0110; inOp = 2'b01;
    @(posedge clk); #1;
    check("pre-rst RESULT out_valid", {31'd0, outValid}, 32'd1);
    @(negedge clk);
    inValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkIdle("rst in RESULT");
    check("rst in RESULT out_data", {28'd0, outData}, 32'd0);
`ifdef LOGIC_SEQ_FLAGS_EN
    check("rst in RESULT out_zero", {31'd0, outZero}, 32'd1);
`endif
    @(negedge clk);
    rst_n = 1'b1; outReady = 1'b1;

    // Fresh transaction after reset; A from before reset must not leak in.
    pre = '{4'b0110, 4'b0011, 2'b10, 4'b0101, 1'b0, 1'b0};
    runVec(pre, "post-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
